// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver: captures every done-tick byte
// and holds it until the consumer pops it; drops and flags pushes that arrive while full.
module uart_rx_fifo #(
  parameter int DBIT = 8,
  parameter int ADDR = 4
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_wr,
  input  logic [DBIT-1:0] i_wr_data,
  input  logic            i_rd,
  input  logic            i_clr_ovf,
  output logic [DBIT-1:0] o_rd_data,
  output logic            o_empty,
  output logic            o_full,
  output logic [ADDR:0]   o_count,
  output logic            o_overflow
);

  localparam int            DEPTH    = 1 << ADDR;
  localparam logic [ADDR:0] FULL_CNT = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] CNT_ONE  = (ADDR+1)'(1);
  localparam logic [ADDR-1:0] PTR_ONE = ADDR'(1);

  logic [DBIT-1:0] mem_q [DEPTH];
  logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            empty_s, full_s, do_push_s, do_pop_s;

  // Next-state: a pop on a full FIFO frees the slot, so a simultaneous push is accepted;
  // a pop on an empty FIFO is ignored even when a push lands in the same cycle.
  always_comb begin
    empty_s   = (count_q == '0);
    full_s    = (count_q == FULL_CNT);
    do_pop_s  = i_rd && !empty_s;
    do_push_s = i_wr && (!full_s || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;

    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A dropped push takes priority over a clear in the same cycle.
    if (i_wr && !do_push_s) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state register; reset discards everything in flight.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge i_clock) begin
    if (!i_reset && do_push_s) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  assign o_rd_data  = empty_s ? '0 : mem_q[rd_ptr_q];
  assign o_empty    = empty_s;
  assign o_full     = full_s;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner sequences and
// randomized traffic, all checked against a queue-based model of the FIFO.
module tb_uart_rx_fifo;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_wr = 1'b0;
  logic [7:0] i_wr_data = 8'h00;
  logic       i_rd = 1'b0;
  logic       i_clr_ovf = 1'b0;
  logic [7:0] o_rd_data;
  logic       o_empty;
  logic       o_full;
  logic [4:0] o_count;
  logic       o_overflow;

  int total = 0;
  int bad = 0;

  logic [7:0] m_q[$];
  logic       m_ovf = 1'b0;

  uart_rx_fifo #(.DBIT(8), .ADDR(4)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_wr(i_wr), .i_wr_data(i_wr_data),
    .i_rd(i_rd), .i_clr_ovf(i_clr_ovf), .o_rd_data(o_rd_data), .o_empty(o_empty),
    .o_full(o_full), .o_count(o_count), .o_overflow(o_overflow)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       rd;
    logic       clr;
    logic       rst;
    int         cnt;
    logic [7:0] rdat;
    logic       ovf;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check popped head, advance model, compare all outputs.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd,
                      input logic clr, input logic rst);
    bit pop_ok, push_ok;
    int n;
    i_wr = wr; i_wr_data = d; i_rd = rd; i_clr_ovf = clr; i_reset = rst;
    if (!rst && rd && m_q.size() > 0) chk("pop_data", {24'd0, o_rd_data}, {24'd0, m_q[0]});
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      pop_ok  = rd && (m_q.size() > 0);
      push_ok = wr && ((m_q.size() < 16) || pop_ok);
      if (pop_ok) void'(m_q.pop_front());
      if (push_ok) m_q.push_back(d);
      if (wr && !push_ok) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    @(posedge i_clock);
    #1;
    n = m_q.size();
    chk("count", {27'd0, o_count}, n);
    chk("empty", {31'd0, o_empty}, {31'd0, n == 0});
    chk("full", {31'd0, o_full}, {31'd0, n == 16});
    chk("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
    chk("head", {24'd0, o_rd_data}, (n > 0) ? {24'd0, m_q[0]} : 32'd0);
  endtask

  initial begin
    bit wr, rd, clr, rst;
    int ph;

    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 1'b0};
    tbl[4]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 2, 8'hA5, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 8'h3C, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1, 8'h5A, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].clr, tbl[i].rst);
      chk("tbl_count", {27'd0, o_count}, tbl[i].cnt);
      chk("tbl_data", {24'd0, o_rd_data}, {24'd0, tbl[i].rdat});
      chk("tbl_empty", {31'd0, o_empty}, {31'd0, tbl[i].cnt == 0});
      chk("tbl_ovf", {31'd0, o_overflow}, {31'd0, tbl[i].ovf});
    end

    // Fill, overflow, set-vs-clear priority, push+pop at full with wrap, drain.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", {31'd0, o_full}, 32'd1);
    chk("fill_count", {27'd0, o_count}, 32'd16);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("drop_ovf", {31'd0, o_overflow}, 32'd1);
    chk("drop_count", {27'd0, o_count}, 32'd16);
    step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    chk("set_wins", {31'd0, o_overflow}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("clr_ovf", {31'd0, o_overflow}, 32'd0);
    chk("full_pushpop_pre", {24'd0, o_rd_data}, 32'h00);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("full_pushpop_cnt", {27'd0, o_count}, 32'd16);
    chk("full_pushpop_ovf", {31'd0, o_overflow}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("drain", {24'd0, o_rd_data}, (i < 15) ? (i + 1) : 32'h77);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_empty", {31'd0, o_empty}, 32'd1);
    chk("drain_zero", {24'd0, o_rd_data}, 32'h00);

    // Reset mid-stream with a push pending, while overflow is set.
    for (int i = 0; i < 17; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", {27'd0, o_count}, 32'd5);
    chk("pre_rst_ovf", {31'd0, o_overflow}, 32'd1);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("rst_count", {27'd0, o_count}, 32'd0);
    chk("rst_empty", {31'd0, o_empty}, 32'd1);
    chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_discard", {24'd0, o_rd_data}, 32'h00);

    // Randomized traffic alternating between fill-heavy and drain-heavy phases.
    for (int c = 0; c < 4000; c++) begin
      ph  = (c / 150) % 2;
      wr  = $urandom_range(0, 99) < (ph ? 80 : 30);
      rd  = $urandom_range(0, 99) < (ph ? 25 : 75);
      clr = $urandom_range(0, 99) < 4;
      rst = $urandom_range(0, 599) == 0;
      step(wr, 8'($urandom), rd, clr, rst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte FIFO placed directly downstream of the UART receiver: it captures every byte flagged by the receiver's one-cycle done pulse and holds it until the consumer (the UART/ALU interface logic) pops it. It decouples the receiver's byte rate from the consumer's processing, so no received byte is lost while the consumer is busy or while the transmitter is returning a result. It is first-word-fall-through: the head byte is always presented on the output while the FIFO is non-empty.

## Interface
- DBIT, 8, data width in bits (matches receiver word width)
- ADDR, 4, address width; depth = 2^ADDR entries (16 by default)

- i_clock  input  1  system clock, all logic on rising edge
- i_reset  input  1  synchronous, active-high reset
- i_wr  input  1  push strobe; connect to receiver done tick (one-cycle pulse)
- i_wr_data  input  DBIT  byte to push, sampled when i_wr=1
- i_rd  input  1  pop strobe from consumer; removes head entry
- i_clr_ovf  input  1  clears sticky overflow flag
- o_rd_data  output  DBIT  head entry (FWFT); 0 when empty
- o_empty  output  1  FIFO holds no entries
- o_full  output  1  FIFO holds 2^ADDR entries
- o_count  output  ADDR+1  number of stored entries, 0..2^ADDR
- o_overflow  output  1  sticky: a push was dropped because FIFO was full

## Operation
- Storage: register array of 2^ADDR × DBIT; write pointer and read pointer, each ADDR bits, wrap modulo 2^ADDR (15 -> 0 at default).
- Count register ADDR+1 bits; o_empty = (count==0), o_full = (count==2^ADDR), both derived from count.
- Per-cycle action, decided from (i_wr, i_rd, empty, full) sampled at the edge:
  - push only, not full: mem[wr_ptr] <= i_wr_data, wr_ptr+1, count+1.
  - push only, full: data dropped, pointers/count unchanged, overflow <= 1.
  - pop only, not empty: rd_ptr+1, count-1.
  - pop only, empty: ignored, no state change, no flag.
  - push and pop, not empty and not full: both performed, count unchanged.
  - push and pop, full: both performed (pop frees the slot written), count unchanged, no overflow.
  - push and pop, empty: push performed, pop ignored, count becomes 1 (no same-cycle bypass).
- o_rd_data = mem[rd_ptr] when count>0, else all zeros.
- Overflow flag: set on a dropped push; cleared by i_clr_ovf; if set and clear occur in the same cycle, set wins.
- Array contents are not cleared by reset; only pointers, count, and flag are.

## Timing
- Reset (i_reset=1 at an edge): wr_ptr=0, rd_ptr=0, count=0 -> o_empty=1, o_full=0, o_count=0, o_overflow=0, o_rd_data=0. Reset overrides i_wr/i_rd in the same cycle; in-flight bytes are discarded.
- Push latency: byte pushed at edge N is on o_rd_data and o_empty=0 from just after edge N (one cycle).
- Pop: consumer uses o_rd_data while i_rd=1; after that edge the next entry (or 0 if now empty) is presented.
- Flags and o_count update on the same edge as the pointer movement; no combinational path from i_wr/i_rd to any output.
- i_rd may be held high continuously; one entry is removed per cycle while non-empty.

## Test plan
- Reset then idle -> o_empty=1, o_full=0, o_count=0, o_rd_data=0x00, o_overflow=0.
- Push 0xA5, 0x3C on separate cycles, then pop twice -> o_rd_data shows 0xA5 one cycle after first push; after first pop 0x3C; after second pop o_empty=1, o_rd_data=0x00.
- Push 16 bytes 0x00..0x0F -> o_full=1, o_count=16; 17th push 0xFF -> dropped, o_overflow=1, o_count=16; pop all 16 -> sequence 0x00..0x0F, 0xFF never appears; i_clr_ovf pulse -> o_overflow=0.
- Full FIFO, push 0x77 and pop same cycle -> count stays 16, no overflow, 0x77 emerges as 16th pop after wrap of wr_ptr 15->0.
- Empty FIFO, push 0x5A and pop same cycle -> o_count=1, o_rd_data=0x5A next cycle; pop on empty alone -> no change.
- Fill 5 entries, assert i_reset mid-stream with i_wr=1 -> next cycle o_count=0, o_empty=1, o_overflow=0, pushed byte discarded.
